// File: rtl/lingret_operand_sequencer.sv
// Byte-serial operand sequencer: collects instruction, operand A and operand B,
// presents them to an external ALU for one EXEC cycle and captures its result.
module lingret_operand_sequencer #(
  parameter logic ACC_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [7:0] o_instruction,
  output logic [7:0] o_data_0,
  output logic [7:0] o_data_1,
  input  logic [7:0] i_result,
  output logic [7:0] o_result,
  output logic       o_done,
  output logic       o_error,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    EXEC   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] instr_q, instr_d;
  logic [7:0] data0_q, data0_d;
  logic [7:0] data1_q, data1_d;
  logic [7:0] result_q, result_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic       accept;

  // Handshake: a byte transfers on a rising edge where i_valid and o_ready are
  // both high; i_valid may drop at any time and o_ready does not wait on it.
  assign o_ready = (state_q != EXEC);
  assign accept  = i_valid && o_ready;

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    result_d = result_q;
    done_d   = 1'b0;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          instr_d = i_data;
          error_d = 1'b0;
          // Accumulator chaining reuses the last result as operand A.
          if (ACC_EN && i_data[3]) begin
            data0_d = result_q;
            state_d = LOAD_B;
          end else begin
            state_d = LOAD_A;
          end
        end
      end
      LOAD_A: begin
        if (accept) begin
          data0_d = i_data;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (accept) begin
          data1_d = i_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = i_result;
        done_d   = 1'b1;
        error_d  = (instr_q[2:0] > 3'b101);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      instr_q  <= 8'h00;
      data0_q  <= 8'h00;
      data1_q  <= 8'h00;
      result_q <= 8'h00;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      result_q <= result_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign o_instruction = instr_q;
  assign o_data_0      = data0_q;
  assign o_data_1      = data1_q;
  assign o_result      = result_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_state       = state_q;

endmodule
